rr_multiplexor: RTL and testbench

Parametrised N-input registered multiplexor with valid/ready handshakes on every input and on the output. It arbitrates between NUM_IN data channels, either round-robin or by an externally forced select, and registers the winning word into a single output stage. It is the sequential successor to the team's combinational 2:1 `multiplexor`, and it is used where several producers share one downstream consumer.

---
 rtl/rr_multiplexor_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/rr_multiplexor.sv | 143 ++++++++++++++
 tb/tb_rr_multiplexor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_multiplexor_pkg.sv
// rr_multiplexor_pkg
// Shared encodings for the registered round-robin multiplexor:
//   MODE_RR / MODE_FORCED : values of the sel_mode input
//   out_state_t           : output-stage state (ST_EMPTY, ST_FULL)
package rr_multiplexor_pkg;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_FORCED = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational rotate-priority picker. Searches in_valid starting at
// (last_grant+1) mod NUM_IN and wrapping, returning the first set channel.
// Ports:
//   in_valid    input  NUM_IN  per-channel request
//   last_grant  input  SEL_W   most recently served channel
//   grant_valid output 1       some channel is requesting
//   grant_idx   output SEL_W   index of the chosen channel
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] in_valid,
  input  logic [SEL_W-1:0]  last_grant,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // (highest priority) is the one left standing at the end of the loop.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int off = NUM_IN; off >= 1; off--) begin
      idx = SEL_W'((int'(last_grant) + off) % NUM_IN);
      if (in_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_multiplexor.sv
// rr_multiplexor
// NUM_IN-input registered multiplexor with valid/ready handshakes. Picks a
// channel round-robin (sel_mode=MODE_RR) or by sel (sel_mode=MODE_FORCED)
// and registers the winning word into a single output stage.
// Optional feature: define RR_MULTIPLEXOR_LOCK_EN to add in_last and
// packet locking (grant sticks to a channel until its last beat).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sel_mode, sel    arbitration mode and forced channel index
//   in_data          packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid/in_ready per-channel handshake (at most one in_ready high)
//   in_last          (lock build only) last beat of a packet per channel
//   mux_out, out_sel registered word and the channel it came from
//   out_valid/out_ready output handshake
module rr_multiplexor
  import rr_multiplexor_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel_mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
`ifdef RR_MULTIPLEXOR_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]        mux_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  localparam int NUM_PAD = 1 << SEL_W;

  out_state_t       state, state_next;
  logic [SEL_W-1:0] last_grant;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             xfer;

  // Padding in_valid up to a power of two makes an out-of-range sel read a
  // zero, so "no grant for sel >= NUM_IN" needs no explicit compare.
  logic [NUM_PAD-1:0] valid_ext;
  assign valid_ext = NUM_PAD'(in_valid);

`ifdef RR_MULTIPLEXOR_LOCK_EN
  logic             lock_active;
  logic [SEL_W-1:0] lock_idx;
`endif

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arbiter (
    .in_valid    (in_valid),
    .last_grant  (last_grant),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // Final grant: forced or round-robin, overridden by an active packet lock.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (sel_mode == MODE_FORCED) begin
      grant_valid = valid_ext[sel];
      grant_idx   = sel;
    end else begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end
`ifdef RR_MULTIPLEXOR_LOCK_EN
    // A locked channel that drops valid stalls everyone else.
    if (lock_active) begin
      grant_valid = in_valid[lock_idx];
      grant_idx   = lock_idx;
    end
`endif
  end

  assign out_valid = (state == ST_FULL);
  assign load_en   = !out_valid || out_ready;
  assign xfer      = load_en && grant_valid;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A load refills the stage even while it drains, giving 1 word/cycle.
  always_comb begin
    state_next = state;
    if (xfer) begin
      state_next = ST_FULL;
    end else if (state == ST_FULL && out_ready) begin
      state_next = ST_EMPTY;
    end
  end

  // last_grant resets to NUM_IN-1 so the first search starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_out    <= '0;
      out_sel    <= '0;
      last_grant <= SEL_W'(NUM_IN - 1);
    end else if (xfer) begin
      mux_out    <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel    <= grant_idx;
      last_grant <= grant_idx;
    end
  end

`ifdef RR_MULTIPLEXOR_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (xfer) begin
      lock_active <= !in_last[grant_idx];
      lock_idx    <= grant_idx;
    end
  end
`endif

endmodule

// File: tb/tb_rr_multiplexor.sv
// tb_rr_multiplexor
// Self-checking bench for rr_multiplexor: a table of directed vectors
// (inputs plus hand-computed in_ready and registered outputs) followed by
// hand-written sequences for reset behaviour and, in the lock build,
// packet locking.
module tb_rr_multiplexor;

  localparam int WIDTH  = 5;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    sel_mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        mux_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;
`ifdef RR_MULTIPLEXOR_LOCK_EN
  logic [NUM_IN-1:0]       in_last;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  rr_multiplexor #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_mode  (sel_mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_MULTIPLEXOR_LOCK_EN
    .in_last   (in_last),
`endif
    .mux_out   (mux_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [19:0] data;
    logic        ready;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [4:0]  exp_mux;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic mode, input logic [1:0] s, input logic [3:0] valid,
                         input logic [19:0] data, input logic ready,
                         input logic [3:0] exp_ready, input logic exp_valid,
                         input logic [4:0] exp_mux, input logic [1:0] exp_sel);
    vec_t v;
    v.mode = mode; v.sel = s; v.valid = valid; v.data = data; v.ready = ready;
    v.exp_ready = exp_ready; v.exp_valid = exp_valid;
    v.exp_mux = exp_mux; v.exp_sel = exp_sel;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic mode, input logic [1:0] s, input logic [3:0] valid,
                               input logic [19:0] data, input logic ready);
    sel_mode  = mode;
    sel       = s;
    in_valid  = valid;
    in_data   = data;
    out_ready = ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Channel words: base set 01..04, ch2 replaced by 15, ch0 replaced by 0A.
  localparam logic [19:0] D_BASE = {5'h04, 5'h03, 5'h02, 5'h01};
  localparam logic [19:0] D_F15  = {5'h04, 5'h15, 5'h02, 5'h01};
  localparam logic [19:0] D_0A   = {5'h04, 5'h15, 5'h02, 5'h0A};
  localparam logic RR = 1'b0;
  localparam logic FO = 1'b1;

  initial begin
    vec_t v;

    // Round-robin over all four channels, starting at channel 0.
    add_vec(RR, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0001, 1'b1, 5'h01, 2'd0);
    add_vec(RR, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0010, 1'b1, 5'h02, 2'd1);
    add_vec(RR, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0100, 1'b1, 5'h03, 2'd2);
    add_vec(RR, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b1000, 1'b1, 5'h04, 2'd3);
    add_vec(RR, 2'd0, 4'b1111, D_BASE, 1'b1, 4'b0001, 1'b1, 5'h01, 2'd0);
    // Sparse requests alternate between channels 1 and 3.
    add_vec(RR, 2'd0, 4'b1010, D_BASE, 1'b1, 4'b0010, 1'b1, 5'h02, 2'd1);
    add_vec(RR, 2'd0, 4'b1010, D_BASE, 1'b1, 4'b1000, 1'b1, 5'h04, 2'd3);
    add_vec(RR, 2'd0, 4'b1010, D_BASE, 1'b1, 4'b0010, 1'b1, 5'h02, 2'd1);
    add_vec(RR, 2'd0, 4'b1010, D_BASE, 1'b1, 4'b1000, 1'b1, 5'h04, 2'd3);
    // Forced select of channel 2, then channel 2 drops valid and the stage drains.
    add_vec(FO, 2'd2, 4'b1111, D_F15, 1'b1, 4'b0100, 1'b1, 5'h15, 2'd2);
    add_vec(FO, 2'd2, 4'b1111, D_F15, 1'b1, 4'b0100, 1'b1, 5'h15, 2'd2);
    add_vec(FO, 2'd2, 4'b1011, D_F15, 1'b1, 4'b0000, 1'b0, 5'h00, 2'd0);
    add_vec(FO, 2'd2, 4'b1011, D_F15, 1'b1, 4'b0000, 1'b0, 5'h00, 2'd0);
    add_vec(FO, 2'd3, 4'b1011, D_F15, 1'b1, 4'b1000, 1'b1, 5'h04, 2'd3);
    // Load 0A from channel 0 (wrap after last_grant=3), then hold 5 cycles.
    add_vec(RR, 2'd0, 4'b0001, D_0A, 1'b1, 4'b0001, 1'b1, 5'h0A, 2'd0);
    for (int i = 0; i < 5; i++)
      add_vec(RR, 2'd0, 4'b1111, D_0A, 1'b0, 4'b0000, 1'b1, 5'h0A, 2'd0);
    // Release: next word loads in the same cycle the held one drains.
    add_vec(RR, 2'd0, 4'b1111, D_0A, 1'b1, 4'b0010, 1'b1, 5'h02, 2'd1);
    // Mode switch takes effect immediately.
    add_vec(FO, 2'd0, 4'b1111, D_0A, 1'b1, 4'b0001, 1'b1, 5'h0A, 2'd0);

    // Reset state.
    rst_n = 1'b0;
`ifdef RR_MULTIPLEXOR_LOCK_EN
    in_last = 4'b1111;
`endif
    applyStimulus(RR, 2'd0, 4'b0000, D_BASE, 1'b0);
    #12;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset mux_out", 32'(mux_out), 32'd0);
    checkOutput("reset out_sel", 32'(out_sel), 32'd0);
    applyStimulus(RR, 2'd0, 4'b1111, D_BASE, 1'b0);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'b0001);
    applyStimulus(RR, 2'd0, 4'b0000, D_BASE, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.mode, v.sel, v.valid, v.data, v.ready);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(v.exp_ready));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(v.exp_valid));
      if (v.exp_valid) begin
        checkOutput($sformatf("vec%0d mux_out", i), 32'(mux_out), 32'(v.exp_mux));
        checkOutput($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(v.exp_sel));
      end
    end

    // Reset pulse while FULL: stage clears without waiting for a clock.
    applyStimulus(RR, 2'd0, 4'b0000, D_BASE, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset mux_out", 32'(mux_out), 32'd0);
    checkOutput("midreset out_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(RR, 2'd0, 4'b1111, D_BASE, 1'b1);
    #1;
    checkOutput("postreset in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    checkOutput("postreset out_valid", 32'(out_valid), 32'd1);
    checkOutput("postreset mux_out", 32'(mux_out), 32'h01);
    checkOutput("postreset out_sel", 32'(out_sel), 32'd0);

`ifdef RR_MULTIPLEXOR_LOCK_EN
    // Channel 1 opens a packet; RR would move on, but the lock holds it.
    begin
      logic [3:0] lasts [4];
      logic       modes [4];
      logic [1:0] sels  [4];
      lasts = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
      modes = '{FO, RR, FO, RR};
      sels  = '{2'd1, 2'd0, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
        in_last = lasts[i];
        applyStimulus(modes[i], sels[i], 4'b1111, D_BASE, 1'b1);
        #1;
        checkOutput($sformatf("lock%0d in_ready", i), 32'(in_ready),
                    (i < 3) ? 32'b0010 : 32'b0100);
        @(posedge clk);
        #1;
        checkOutput($sformatf("lock%0d out_sel", i), 32'(out_sel),
                    (i < 3) ? 32'd1 : 32'd2);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
